// File: rtl/bus_pkg.sv
// Shared definitions for the IFU/LSU memory-port arbiter.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

endpackage

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store,
// with a single outstanding transaction.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    ifu_req_valid,
    output logic                    ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0]   ifu_addr,
    output logic                    ifu_resp_valid,
    output logic [DATA_WIDTH-1:0]   ifu_rdata,

    input  logic                    lsu_req_valid,
    output logic                    lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0]   lsu_addr,
    input  logic                    lsu_wen,
    input  logic [DATA_WIDTH-1:0]   lsu_wdata,
    input  logic [DATA_WIDTH/8-1:0] lsu_wmask,
    output logic                    lsu_resp_valid,
    output logic [DATA_WIDTH-1:0]   lsu_rdata,

    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_wen,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    input  logic                    mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    state_t state;
    logic   last_grant;
    logic   owner;
    logic   grant_ifu;
    logic   grant_lsu;

    // Readies are held low while rst is asserted so no handshake can be seen during reset.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (state == IDLE && !rst) begin
            if (ifu_req_valid && lsu_req_valid) begin
                if (last_grant == OWN_IFU) grant_lsu = 1'b1;
                else                       grant_ifu = 1'b1;
            end else if (lsu_req_valid) begin
                grant_lsu = 1'b1;
            end else if (ifu_req_valid) begin
                grant_ifu = 1'b1;
            end
        end
    end

    assign ifu_req_ready = grant_ifu;
    assign lsu_req_ready = grant_lsu;
    assign mem_req_valid = (state == REQ);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            last_grant     <= OWN_IFU;
            owner          <= OWN_IFU;
            mem_addr       <= '0;
            mem_wen        <= 1'b0;
            mem_wdata      <= '0;
            mem_wmask      <= '0;
            ifu_rdata      <= '0;
            lsu_rdata      <= '0;
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;
        end else begin
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_ifu) begin
                        mem_addr   <= ifu_addr;
                        mem_wen    <= 1'b0;
                        mem_wdata  <= '0;
                        mem_wmask  <= '0;
                        owner      <= OWN_IFU;
                        last_grant <= OWN_IFU;
                        state      <= REQ;
                    end else if (grant_lsu) begin
                        mem_addr   <= lsu_addr;
                        mem_wen    <= lsu_wen;
                        mem_wdata  <= lsu_wdata;
                        mem_wmask  <= lsu_wmask;
                        owner      <= OWN_LSU;
                        last_grant <= OWN_LSU;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) state <= WAIT;
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        if (owner == OWN_IFU) begin
                            ifu_rdata      <= mem_rdata;
                            ifu_resp_valid <= 1'b1;
                        end else begin
                            if (!mem_wen) lsu_rdata <= mem_rdata;
                            lsu_resp_valid <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: memory responder model plus a response scoreboard.
module tb_bus_arbiter;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    typedef struct packed {
        logic        owner;
        logic [31:0] data;
        logic        store;
    } exp_t;

    exp_t        sb[$];
    int unsigned tests_run = 0;
    int unsigned failures  = 0;
    int unsigned ready_delay = 0;
    int unsigned resp_delay  = 0;
    int unsigned stray_tok   = 0;
    logic [31:0] ifu_rd_m = '0;
    logic [31:0] lsu_rd_m = '0;

    bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'h0010_0093 : ((a ^ 32'h5A5A_A5A5) + 32'h1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory: ready after ready_delay cycles of mem_req_valid, response resp_delay cycles later.
    initial begin : mem_model
        int unsigned rcnt = 0;
        int unsigned cnt  = 0;
        int unsigned seen_tok = 0;
        bit          ready_now = 1'b0;
        bit          pending   = 1'b0;
        logic [31:0] p_addr = '0;
        logic        p_wen  = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        forever begin
            @(posedge clk); #1;
            mem_resp_valid = 1'b0;
            if (stray_tok != seen_tok) begin
                seen_tok       = stray_tok;
                mem_resp_valid = 1'b1;
                mem_rdata      = 32'hBAD0_C0DE;
            end else if (ready_now) begin
                ready_now     = 1'b0;
                mem_req_ready = 1'b0;
                if (resp_delay == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_rdata      = p_wen ? 32'h0 : mem_fn(p_addr);
                end else begin
                    pending = 1'b1;
                    cnt     = resp_delay - 1;
                end
            end else if (pending) begin
                if (cnt == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_rdata      = p_wen ? 32'h0 : mem_fn(p_addr);
                    pending        = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (mem_req_valid) begin
                if (rcnt >= ready_delay) begin
                    mem_req_ready = 1'b1;
                    ready_now     = 1'b1;
                    p_addr        = mem_addr;
                    p_wen         = mem_wen;
                    rcnt          = 0;
                end else begin
                    rcnt++;
                end
            end else begin
                rcnt = 0;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (ifu_resp_valid === 1'b1 || lsu_resp_valid === 1'b1) begin
                chk("resp_exclusive", {63'b0, ifu_resp_valid & lsu_resp_valid}, 64'd0);
                if (sb.size() == 0) begin
                    tests_run++;
                    failures++;
                    $error("FAIL unexpected_resp observed ifu=%b lsu=%b expected no pulse",
                           ifu_resp_valid, lsu_resp_valid);
                end else begin
                    e = sb.pop_front();
                    chk("resp_owner", {63'b0, lsu_resp_valid}, {63'b0, e.owner});
                    if (!e.store)
                        chk("resp_rdata", (e.owner == OWN_LSU) ? lsu_rdata : ifu_rdata, e.data);
                    if (e.owner == OWN_IFU) ifu_rd_m = e.data;
                    else if (!e.store)      lsu_rd_m = e.data;
                end
            end
        end
    end

    // Waits for a ready, checks it belongs to exp_owner and records the expected response.
    task automatic grant(input logic exp_owner, input string tag);
        int unsigned n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ifu_req_ready || lsu_req_ready) && n < 40);
        if (!(ifu_req_ready || lsu_req_ready)) begin
            tests_run++;
            failures++;
            $error("FAIL %s_timeout observed no ready expected a grant within 40 cycles", tag);
        end else begin
            chk({tag, "_grant"}, {62'b0, ifu_req_ready, lsu_req_ready},
                (exp_owner == OWN_LSU) ? 64'd1 : 64'd2);
            if (exp_owner == OWN_LSU)
                sb.push_back('{OWN_LSU, lsu_wen ? 32'h0 : mem_fn(lsu_addr), lsu_wen});
            else
                sb.push_back('{OWN_IFU, mem_fn(ifu_addr), 1'b0});
        end
        @(posedge clk); #1;
    endtask

    task automatic drain(input string tag);
        int unsigned n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            tests_run++;
            failures++;
            $error("FAIL %s_drain observed %0d pending expected 0", tag, sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        ifu_rd_m = '0;
        lsu_rd_m = '0;
        repeat (2) @(negedge clk);
        chk("rst_ifu_ready",  {63'b0, ifu_req_ready},  64'd0);
        chk("rst_lsu_ready",  {63'b0, lsu_req_ready},  64'd0);
        chk("rst_mem_valid",  {63'b0, mem_req_valid},  64'd0);
        chk("rst_mem_addr",   {32'b0, mem_addr},       64'd0);
        chk("rst_mem_wdata",  {32'b0, mem_wdata},      64'd0);
        chk("rst_mem_wmask",  {60'b0, mem_wmask},      64'd0);
        chk("rst_ifu_resp",   {63'b0, ifu_resp_valid}, 64'd0);
        chk("rst_lsu_resp",   {63'b0, lsu_resp_valid}, 64'd0);
        chk("rst_ifu_rdata",  {32'b0, ifu_rdata},      64'd0);
        chk("rst_lsu_rdata",  {32'b0, lsu_rdata},      64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin : stimulus
        rst = 1'b1;
        ifu_req_valid = 1'b0; ifu_addr = '0;
        lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        do_reset();
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;

        // Single fetch, minimum latency.
        ifu_addr = 32'h8000_0000;
        ifu_req_valid = 1'b1;
        grant(OWN_IFU, "t1");
        ifu_req_valid = 1'b0;
        ifu_addr = 32'h0;
        @(negedge clk);
        chk("t1_mem_valid", {63'b0, mem_req_valid}, 64'd1);
        chk("t1_mem_addr",  {32'b0, mem_addr},      64'h8000_0000);
        chk("t1_mem_wen",   {63'b0, mem_wen},       64'd0);
        chk("t1_mem_wmask", {60'b0, mem_wmask},     64'd0);
        @(negedge clk);
        chk("t1_resp_early", {63'b0, ifu_resp_valid}, 64'd0);
        @(negedge clk);
        chk("t1_resp_t3",   {63'b0, ifu_resp_valid}, 64'd1);
        chk("t1_rdata",     {32'b0, ifu_rdata},      64'h0010_0093);
        chk("t1_lsu_quiet", {63'b0, lsu_resp_valid}, 64'd0);
        @(negedge clk);
        chk("t1_pulse_end", {63'b0, ifu_resp_valid}, 64'd0);
        drain("t1");

        // First tie after reset goes to LSU.
        do_reset();
        ifu_addr = 32'h8000_0004;
        lsu_addr = 32'h8000_2000;
        lsu_wen  = 1'b0;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        grant(OWN_LSU, "t2_first");
        lsu_req_valid = 1'b0;
        grant(OWN_IFU, "t2_second");
        ifu_req_valid = 1'b0;
        drain("t2");

        // Continuous contention alternates.
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                grant(OWN_LSU, "t3_lsu");
                lsu_addr = lsu_addr + 32'h4;
            end else begin
                grant(OWN_IFU, "t3_ifu");
                ifu_addr = ifu_addr + 32'h4;
            end
        end
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        drain("t3");

        // Stray memory response while idle.
        stray_tok++;
        repeat (3) begin
            @(negedge clk);
            chk("stray_ifu_resp", {63'b0, ifu_resp_valid}, 64'd0);
            chk("stray_lsu_resp", {63'b0, lsu_resp_valid}, 64'd0);
        end
        chk("stray_ifu_rdata", {32'b0, ifu_rdata}, {32'b0, ifu_rd_m});
        chk("stray_lsu_rdata", {32'b0, lsu_rdata}, {32'b0, lsu_rd_m});
        chk("stray_mem_valid", {63'b0, mem_req_valid}, 64'd0);
        @(posedge clk); #1;

        // Store with a stalled memory port.
        ready_delay = 3;
        lsu_addr  = 32'h8000_1000;
        lsu_wdata = 32'hDEAD_BEEF;
        lsu_wmask = 4'hF;
        lsu_wen   = 1'b1;
        lsu_req_valid = 1'b1;
        grant(OWN_LSU, "t4");
        lsu_req_valid = 1'b0;
        lsu_addr  = '0;
        lsu_wdata = '0;
        lsu_wmask = '0;
        lsu_wen   = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("t4_mem_valid", {63'b0, mem_req_valid}, 64'd1);
            chk("t4_mem_addr",  {32'b0, mem_addr},      64'h8000_1000);
            chk("t4_mem_wdata", {32'b0, mem_wdata},     64'hDEAD_BEEF);
            chk("t4_mem_wmask", {60'b0, mem_wmask},     64'hF);
            chk("t4_mem_wen",   {63'b0, mem_wen},       64'd1);
        end
        drain("t4");
        ready_delay = 0;

        // Reset while waiting for the response; the late response must be dropped.
        resp_delay = 4;
        lsu_addr = 32'h8000_3000;
        lsu_req_valid = 1'b1;
        grant(OWN_LSU, "t5");
        lsu_req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t5_in_wait", {63'b0, mem_req_valid}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        ifu_rd_m = '0;
        lsu_rd_m = '0;
        lsu_req_valid = 1'b1;
        #1;
        chk("t5_rst_ready", {63'b0, lsu_req_ready}, 64'd0);
        chk("t5_rst_mem_valid", {63'b0, mem_req_valid}, 64'd0);
        chk("t5_rst_mem_addr", {32'b0, mem_addr}, 64'd0);
        @(negedge clk);
        lsu_req_valid = 1'b0;
        rst = 1'b0;
        resp_delay = 0;
        repeat (6) begin
            @(negedge clk);
            chk("t5_no_lsu_resp", {63'b0, lsu_resp_valid}, 64'd0);
            chk("t5_no_ifu_resp", {63'b0, ifu_resp_valid}, 64'd0);
        end
        chk("t5_lsu_rdata", {32'b0, lsu_rdata}, 64'd0);
        @(posedge clk); #1;
        ifu_addr = 32'h8000_0010;
        lsu_addr = 32'h8000_2010;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        grant(OWN_LSU, "t5_tie");
        lsu_req_valid = 1'b0;
        grant(OWN_IFU, "t5_next");
        ifu_req_valid = 1'b0;
        drain("t5");

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; the wmask width is DATA_WIDTH/8.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 ifu_req_valid  in  1  instruction-fetch request.
REQ-006 ifu_req_ready  out  1  fetch request accepted this cycle.
REQ-007 ifu_addr  in  ADDR_WIDTH  fetch address.
REQ-008 ifu_resp_valid  out  1  one-cycle pulse: fetch data available.
REQ-009 ifu_rdata  out  DATA_WIDTH  fetched instruction.
REQ-010 lsu_req_valid  in  1  load/store request.
REQ-011 lsu_req_ready  out  1  load/store request accepted this cycle.
REQ-012 lsu_addr  in  ADDR_WIDTH  load/store address.
REQ-013 lsu_wen  in  1  1 = store, 0 = load.
REQ-014 lsu_wdata  in  DATA_WIDTH  store data.
REQ-015 lsu_wmask  in  DATA_WIDTH/8  store byte mask.
REQ-016 lsu_resp_valid  out  1  one-cycle pulse: load data available or store completed.
REQ-017 lsu_rdata  out  DATA_WIDTH  load data.
REQ-018 mem_req_valid  out  1  request to the shared memory port.
REQ-019 mem_req_ready  in  1  memory accepts the request.
REQ-020 mem_addr, mem_wen, mem_wdata, mem_wmask  out  ADDR_WIDTH/1/DATA_WIDTH/DATA_WIDTH/8  latched request fields.
REQ-021 mem_resp_valid  in  1  memory response strobe.
REQ-022 mem_rdata  in  DATA_WIDTH  memory read data.

Function
REQ-023 The FSM SHALL have three states: IDLE, REQ and WAIT.
REQ-024 At most one transaction SHALL be outstanding at any time.
REQ-025 In IDLE, the block SHALL assert the ready of exactly one valid requester; with none valid, both readies SHALL be 0.
REQ-026 With both requesters valid, the block SHALL grant the requester not granted last (last_grant register, round-robin).
REQ-027 A handshake (valid & ready) SHALL latch the address, wen, wdata, wmask and owner, then move the FSM to REQ.
REQ-028 IFU requests SHALL be issued with wen=0 and wmask=0.
REQ-029 In REQ, mem_req_valid SHALL be 1 with the latched fields held stable; mem_req_ready=1 SHALL move the FSM to WAIT.
REQ-030 In WAIT, mem_resp_valid=1 SHALL register mem_rdata into the owner's rdata, pulse the owner's resp_valid for exactly one cycle on the next cycle, and return the FSM to IDLE.
REQ-031 A new request SHALL be acceptable in the same cycle as that resp_valid pulse.
REQ-032 mem_resp_valid outside WAIT SHALL be ignored.
REQ-033 The memory SHALL respond at least one cycle after the request handshake.
REQ-034 Minimum latency, request handshake at T: mem_req_valid at T+1; mem_resp_valid at T+2 earliest; resp_valid at T+3.
REQ-035 Stores SHALL also complete via mem_resp_valid and produce an lsu_resp_valid pulse; lsu_rdata is don't-care after a store.
REQ-036 The non-owning requester's resp_valid SHALL never pulse.
REQ-037 rdata outputs SHALL hold their value until the next response to the same requester.

Reset
REQ-038 On rst (asynchronous, mid-transaction included): state IDLE; last_grant=IFU, so the first tie goes to LSU.
REQ-039 On rst: all ready, valid and resp outputs 0; latched fields and rdata 0.
REQ-040 On rst: any in-flight transaction SHALL be abandoned, and a late mem_resp_valid SHALL be ignored.

Structure
REQ-041 Package bus_pkg SHALL hold the state enum (IDLE/REQ/WAIT) and the owner constants (OWN_IFU=0, OWN_LSU=1).
REQ-042 The block SHALL be a single module with no sub-module; the grant logic is inline.

Verification
REQ-043 IFU only, ifu_addr=0x80000000, mem ready immediately, resp 1 cycle later with rdata=0x00100093 -> ifu_resp_valid at T+3, ifu_rdata=0x00100093, lsu_resp_valid stays 0.
REQ-044 IFU and LSU valid in the same cycle after reset -> LSU granted first; IFU granted on the next IDLE.
REQ-045 Both valid continuously for 4 grants -> order LSU, IFU, LSU, IFU.
REQ-046 LSU store, addr=0x80001000, wdata=0xDEADBEEF, wmask=0xF; mem_req_ready held 0 for 3 cycles -> mem fields stable throughout, single lsu_resp_valid pulse.
REQ-047 rst asserted in WAIT, then mem_resp_valid after release -> no resp_valid pulse, FSM in IDLE.
REQ-048 Stray mem_resp_valid in IDLE -> no output change.
